// File: rtl/riscv_multicycle_ctrl.sv
// Main sequencing FSM for the multicycle RV32I core: drives the shared ALU and
// shared memory datapath, stalling memory states on the MemReady handshake.
module riscv_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic [3:0] nzcv,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [4:0] ALUControl,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_XOR = 5'b00100;
  localparam logic [4:0] ALU_SLT = 5'b00101;
  localparam logic [4:0] ALU_SLL = 5'b00110;
  localparam logic [4:0] ALU_SRL = 5'b00111;

  state_t r_state;
  state_t w_next;
  logic   w_pcwrite;
  logic   w_irwrite;
  logic   w_memwrite;
  logic   w_regwrite;
  // Carry flag has no consumer in the supported branch set.
  logic   w_unused_c;

  function automatic logic [4:0] alu_dec(input logic [2:0] f3, input logic f7,
                                         input logic is_r);
    case (f3)
      3'b000:  alu_dec = (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_dec = ALU_AND;
      3'b110:  alu_dec = ALU_OR;
      3'b100:  alu_dec = ALU_XOR;
      3'b010:  alu_dec = ALU_SLT;
      3'b001:  alu_dec = ALU_SLL;
      3'b101:  alu_dec = ALU_SRL;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [3:0] f);
    case (f3)
      3'b000:  br_taken = f[2];
      3'b001:  br_taken = ~f[2];
      3'b100:  br_taken = f[3] ^ f[0];
      3'b101:  br_taken = ~(f[3] ^ f[0]);
      default: br_taken = 1'b0;
    endcase
  endfunction

  assign w_unused_c = nzcv[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = S_FETCH;
    w_pcwrite  = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irwrite = MemReady;
        w_pcwrite = MemReady;
        w_next    = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_BR:        w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (opcode == OP_LW)      w_next = S_MEMREAD;
        else if (opcode == OP_SW) w_next = S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
        w_next     = MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        w_regwrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec(funct3, funct7, 1'b1);
        w_next     = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(funct3, funct7, 1'b0);
        w_next     = S_ALUWB;
      end
      S_ALUWB: w_regwrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        w_pcwrite  = br_taken(funct3, nzcv);
      end
      // PC takes the target from ALUOut while OldPC+4 is formed for the link.
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Strobes are masked by rst so an abort never leaks a partial write.
  assign PCWrite  = w_pcwrite  & ~rst;
  assign IRWrite  = w_irwrite  & ~rst;
  assign MemWrite = w_memwrite & ~rst;
  assign RegWrite = w_regwrite & ~rst;
  assign State    = r_state;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Cycle-by-cycle check of the multicycle controller against a hand-built
// table of expected state and control outputs.
module tb_riscv_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7;
  logic [3:0] nzcv;
  logic       MemReady;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [4:0] ALUControl;
  logic [3:0] State;

  riscv_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .nzcv(nzcv), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [3:0]  nz;
    logic        mr;
    logic [21:0] exp;
  } vec_t;

  vec_t        vt[$];
  logic [21:0] sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [6:0]  c_op;
  logic [2:0]  c_f3;
  logic        c_f7;
  logic [3:0]  c_nz;

  // {State, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl}
  wire [21:0] w_act = {State, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
                       ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

  function automatic logic [21:0] pack(input logic [3:0] st, input logic pcw, adr, irw, mw, rw,
                                       input logic [1:0] rs, sa, sb, imm, input logic [4:0] alu);
    return {st, pcw, adr, irw, mw, rw, rs, sa, sb, imm, alu};
  endfunction

  task automatic ins(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic [3:0] nz);
    c_op = op; c_f3 = f3; c_f7 = f7; c_nz = nz;
  endtask

  task automatic row(input logic mr, input logic [3:0] st, input logic pcw, adr, irw, mw, rw,
                     input logic [1:0] rs, sa, sb, imm, input logic [4:0] alu);
    vec_t v;
    v.op = c_op; v.f3 = c_f3; v.f7 = c_f7; v.nz = c_nz; v.mr = mr;
    v.exp = pack(st, pcw, adr, irw, mw, rw, rs, sa, sb, imm, alu);
    vt.push_back(v);
  endtask

  task automatic fetch(input logic mr, input logic [1:0] imm);
    row(mr, 0, mr, 0, mr, 0, 0, 2, 0, 2, imm, 0);
  endtask
  task automatic decode(input logic [1:0] imm);
    row(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, imm, 0);
  endtask
  task automatic aluwb(input logic [1:0] imm);
    row(1, 8, 0, 0, 0, 0, 1, 0, 0, 0, imm, 0);
  endtask
  task automatic rtype(input logic [2:0] f3, input logic f7, input logic [4:0] alu);
    ins(RT, f3, f7, 0); fetch(1, 0); decode(0);
    row(1, 6, 0, 0, 0, 0, 0, 0, 2, 0, 0, alu); aluwb(0);
  endtask
  task automatic itype(input logic [2:0] f3, input logic f7, input logic [4:0] alu);
    ins(IA, f3, f7, 0); fetch(1, 0); decode(0);
    row(1, 7, 0, 0, 0, 0, 0, 0, 2, 1, 0, alu); aluwb(0);
  endtask
  task automatic branch(input logic [2:0] f3, input logic [3:0] nz, input logic taken);
    ins(BR, f3, 0, nz); fetch(1, 2); decode(2);
    row(1, 9, taken, 0, 0, 0, 0, 0, 2, 0, 2, 1);
  endtask

  task automatic check(input string nm);
    logic [21:0] e;
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", nm, w_act);
    end else begin
      e = sb_q.pop_front();
      n_tests++;
      if (w_act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, w_act, e);
      end
    end
  endtask

  // Called at a falling edge; leaves the bench at the falling edge after the last row.
  task automatic run_vecs(input string nm);
    foreach (vt[i]) begin
      opcode = vt[i].op; funct3 = vt[i].f3; funct7 = vt[i].f7;
      nzcv = vt[i].nz; MemReady = vt[i].mr;
      sb_q.push_back(vt[i].exp);
      #1;
      check($sformatf("%s[%0d]", nm, i));
      @(negedge clk);
    end
    vt.delete();
  endtask

  initial begin
    rst = 1'b1; opcode = RT; funct3 = 0; funct7 = 0; nzcv = 0; MemReady = 1'b1;
    @(negedge clk);
    sb_q.push_back(pack(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0));
    check("reset_a");
    @(negedge clk);
    sb_q.push_back(pack(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0));
    check("reset_b");
    rst = 1'b0;

    rtype(3'b000, 0, 5'd0);
    rtype(3'b000, 1, 5'd1);
    rtype(3'b111, 0, 5'd2);
    rtype(3'b110, 0, 5'd3);
    rtype(3'b100, 0, 5'd4);
    rtype(3'b010, 0, 5'd5);
    rtype(3'b001, 0, 5'd6);
    rtype(3'b101, 1, 5'd7);
    rtype(3'b011, 0, 5'd0);
    itype(3'b000, 1, 5'd0);
    itype(3'b010, 0, 5'd5);
    itype(3'b101, 1, 5'd7);
    itype(3'b111, 0, 5'd2);
    ins(LW, 3'b010, 0, 0); fetch(1, 0); decode(0);
    row(1, 2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
    row(0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    ins(SW, 3'b010, 0, 0); fetch(0, 1); fetch(1, 1); decode(1);
    row(1, 2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0);
    row(0, 5, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    row(1, 5, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    branch(3'b001, 4'b0100, 0);
    branch(3'b001, 4'b0000, 1);
    branch(3'b000, 4'b0100, 1);
    branch(3'b000, 4'b0000, 0);
    branch(3'b100, 4'b1000, 1);
    branch(3'b100, 4'b1001, 0);
    branch(3'b101, 4'b1000, 0);
    branch(3'b101, 4'b0000, 1);
    branch(3'b010, 4'b0100, 0);
    ins(JL, 3'b000, 0, 0); fetch(1, 3); decode(3);
    row(1, 10, 1, 0, 0, 0, 0, 0, 1, 2, 3, 0); aluwb(3);
    ins(7'h7F, 3'b000, 0, 0); fetch(1, 0); decode(0);
    run_vecs("prog");

    // Store stalled in MEMWRITE, then aborted by an asynchronous reset.
    ins(SW, 3'b010, 0, 0); fetch(1, 1); decode(1);
    row(1, 2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0);
    row(0, 5, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    run_vecs("sw_abort");
    MemReady = 1'b0;
    sb_q.push_back(pack(5, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));
    #1 check("memwrite_stall");
    #2 rst = 1'b1;
    sb_q.push_back(pack(0, 0, 0, 0, 0, 0, 2, 0, 2, 1, 0));
    #1 check("rst_async");
    @(negedge clk);
    sb_q.push_back(pack(0, 0, 0, 0, 0, 0, 2, 0, 2, 1, 0));
    #1 check("rst_held");
    rst = 1'b0; MemReady = 1'b1;
    sb_q.push_back(pack(0, 1, 0, 1, 0, 0, 2, 0, 2, 1, 0));
    #1 check("refetch");
    @(negedge clk);
    sb_q.push_back(pack(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    #1 check("redecode");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
